// File: rtl/mse_collector_bank.sv
// Multi-channel sum-of-squared-error collector: accumulates (data_in - data_ref)^2
// per channel over one window, then streams the per-channel results out over valid/ready.

module mse_lane #(
  parameter int DATA_W = 29,
  parameter int ACC_W  = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_ref,
  output logic [ACC_W-1:0]  acc
);
  localparam int SQ_W  = 2*DATA_W + 2;
  localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

  logic signed [DATA_W:0] diff;
  logic signed [SQ_W-1:0] dx, prod;
  logic [SUM_W-1:0]       sum;

  // One extra bit keeps the difference exact for the full signed input range
  assign diff = $signed({data_in[DATA_W-1], data_in}) - $signed({data_ref[DATA_W-1], data_ref});
  assign dx   = {{(SQ_W-DATA_W-1){diff[DATA_W]}}, diff};
  assign prod = dx * dx;
  // Anything above ACC_W, whether from the square itself or the carry, means saturate
  assign sum  = SUM_W'(acc) + SUM_W'($unsigned(prod));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      acc <= '0;
    else if (clr)                   acc <= '0;
    else if (en) begin
      if (|sum[SUM_W-1:ACC_W])      acc <= '1;
      else                          acc <= sum[ACC_W-1:0];
    end
  end
endmodule

module mse_collector_bank #(
  parameter int NUM_CAND    = 2,
  parameter int DATA_W      = 29,
  parameter int ACC_W       = 64,
  parameter int NUM_SAMPLES = 1024,
  parameter int SKIP_CYCLES = 8,
  localparam int CHAN_W     = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [NUM_CAND-1:0][DATA_W-1:0] data_in,
  input  logic [NUM_CAND-1:0][DATA_W-1:0] data_ref,
  output logic [ACC_W-1:0]                res_data,
  output logic [CHAN_W-1:0]               res_chan,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            busy,
  output logic                            done
);
  localparam int CNT_MAX = (NUM_SAMPLES > SKIP_CYCLES) ? NUM_SAMPLES : SKIP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  SKIP_LAST = CNT_W'((SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]  SAMP_LAST = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CHAN_W-1:0] LAST_IDX  = CHAN_W'(NUM_CAND - 1);

  typedef enum logic [1:0] {IDLE, SKIP, ACCUM, OUTPUT} state_t;

  state_t                        state, state_nxt;
  logic [CNT_W-1:0]              cnt;
  logic [CHAN_W-1:0]             idx;
  logic [NUM_CAND-1:0][ACC_W-1:0] acc;
  logic                          clr, en, hs;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (SKIP_CYCLES > 0) ? SKIP : ACCUM;
      SKIP:    if (cnt == SKIP_LAST) state_nxt = ACCUM;
      ACCUM:   if (cnt == SAMP_LAST) state_nxt = OUTPUT;
      OUTPUT:  if (res_ready && idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res_valid = (state == OUTPUT);
    busy      = (state != IDLE);
    clr       = (state == IDLE) && start;
    en        = (state == ACCUM);
    hs        = res_valid && res_ready;
  end

  // cnt restarts on every state change, so it serves both SKIP and ACCUM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      idx  <= '0;
      done <= 1'b0;
    end else begin
      if (state != state_nxt)                   cnt <= '0;
      else if (state == SKIP || state == ACCUM) cnt <= cnt + 1'b1;
      if (state == ACCUM)                       idx <= '0;
      else if (hs && idx != LAST_IDX)           idx <= idx + 1'b1;
      done <= hs && (idx == LAST_IDX);
    end
  end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_lane
    mse_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .clr      (clr),
      .en       (en),
      .data_in  (data_in[g]),
      .data_ref (data_ref[g]),
      .acc      (acc[g])
    );
  end

  // Accumulators and idx are registers, so the result is stable under backpressure
  assign res_data = acc[idx];
  assign res_chan = idx;
endmodule

// File: tb/tb_mse_collector_bank.sv
// Scoreboard bench: stimulus pushes expected per-channel results, monitors pop on each handshake.
module tb_mse_collector_bank;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {int chan; logic [63:0] data;} exp_t;
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  logic dexp_a = 1'b0;

  // A: main config; B: 8-bit saturating accumulators, no skip; C: single channel, single sample
  logic             start_a, rready_a, rvalid_a, busy_a, done_a;
  logic [1:0][28:0] din_a, dref_a;
  logic [63:0]      rdata_a;
  logic [0:0]       rchan_a;

  logic             start_b, rready_b, rvalid_b, busy_b, done_b;
  logic [1:0][28:0] din_b, dref_b;
  logic [7:0]       rdata_b;
  logic [0:0]       rchan_b;

  logic             start_c, rready_c, rvalid_c, busy_c, done_c;
  logic [0:0][28:0] din_c, dref_c;
  logic [63:0]      rdata_c;
  logic [0:0]       rchan_c;

  logic [2:0] dn;
  assign dn = {done_c, done_b, done_a};

  mse_collector_bank #(.NUM_CAND(2), .DATA_W(29), .ACC_W(64), .NUM_SAMPLES(16), .SKIP_CYCLES(4)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .data_in(din_a), .data_ref(dref_a),
    .res_data(rdata_a), .res_chan(rchan_a), .res_valid(rvalid_a), .res_ready(rready_a),
    .busy(busy_a), .done(done_a));

  mse_collector_bank #(.NUM_CAND(2), .DATA_W(29), .ACC_W(8), .NUM_SAMPLES(16), .SKIP_CYCLES(0)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .data_in(din_b), .data_ref(dref_b),
    .res_data(rdata_b), .res_chan(rchan_b), .res_valid(rvalid_b), .res_ready(rready_b),
    .busy(busy_b), .done(done_b));

  mse_collector_bank #(.NUM_CAND(1), .DATA_W(29), .ACC_W(64), .NUM_SAMPLES(1), .SKIP_CYCLES(0)) dut_c (
    .clk(clk), .rstn(rstn), .start(start_c), .data_in(din_c), .data_ref(dref_c),
    .res_data(rdata_c), .res_chan(rchan_c), .res_valid(rvalid_c), .res_ready(rready_c),
    .busy(busy_c), .done(done_c));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    while (dn[k] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (dn[k] !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_timeout dut=%0d actual=0 required=1", k);
    end
  endtask

  // Monitors: pop on every accepted transfer
  always @(negedge clk) begin
    if (rstn && rvalid_a && rready_a) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected chan=%0d data=%0d required=none", rchan_a, rdata_a);
      end else begin
        ea = qa.pop_front();
        check("a_chan", 64'(rchan_a), 64'(ea.chan));
        check("a_data", rdata_a, ea.data);
      end
    end
    check("a_done", 64'(done_a), 64'(dexp_a));
    dexp_a = rstn && rvalid_a && rready_a && (rchan_a == 1'b1);
  end

  always @(negedge clk) begin
    if (rstn && rvalid_b && rready_b) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected chan=%0d data=%0d required=none", rchan_b, rdata_b);
      end else begin
        eb = qb.pop_front();
        check("b_chan", 64'(rchan_b), 64'(eb.chan));
        check("b_data", 64'(rdata_b), eb.data);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && rvalid_c && rready_c) begin
      if (qc.size() == 0) begin
        total++; bad++;
        $display("FAIL c_unexpected chan=%0d data=%0d required=none", rchan_c, rdata_c);
      end else begin
        ec = qc.pop_front();
        check("c_chan", 64'(rchan_c), 64'(ec.chan));
        check("c_data", rdata_c, ec.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    start_a = 0; start_b = 0; start_c = 0;
    rready_a = 1; rready_b = 1; rready_c = 1;
    din_a = '0; dref_a = '0; din_b = '0; dref_b = '0; din_c = '0; dref_c = '0;
    #3;
    check("rst_busy", 64'(busy_a), 0);
    check("rst_valid", 64'(rvalid_a), 0);
    check("rst_data", rdata_a, 0);
    check("rst_chan", 64'(rchan_a), 0);
    check("rst_done", 64'(done_a), 0);
    @(posedge clk); #1 rstn = 1;
    tick();

    // Window 1: basic result plus first-valid latency
    din_a[0] = 29'd5; dref_a[0] = 29'd2; din_a[1] = 29'd7; dref_a[1] = 29'd7;
    qa.push_back('{0, 64'd144}); qa.push_back('{1, 64'd0});
    start_a = 1; tick(); start_a = 0;
    cyc = 1;
    while (!rvalid_a && cyc < 100) begin tick(); cyc++; end
    check("a_latency", 64'(cyc), 21);
    wait_done(0); tick();

    // Window 2: signed operands
    din_a[0] = 29'(-3); dref_a[0] = 29'd4; din_a[1] = 29'd100; dref_a[1] = 29'(-100);
    qa.push_back('{0, 64'd784}); qa.push_back('{1, 64'd640000});
    start_a = 1; tick(); start_a = 0;
    wait_done(0); tick();

    // Window 3: start ignored while busy, backpressure holds output
    rready_a = 0;
    din_a[0] = 29'd1; dref_a[0] = 29'd0; din_a[1] = 29'd0; dref_a[1] = 29'd3;
    qa.push_back('{0, 64'd16}); qa.push_back('{1, 64'd144});
    start_a = 1; tick(); start_a = 0;
    tick(); tick();
    start_a = 1; tick(); start_a = 0;
    check("skip_busy", 64'(busy_a), 1);
    repeat (6) tick();
    start_a = 1; tick(); start_a = 0;
    check("accum_busy", 64'(busy_a), 1);
    cyc = 0;
    while (!rvalid_a && cyc < 100) begin tick(); cyc++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(rvalid_a), 1);
      check("bp_chan", 64'(rchan_a), 0);
      check("bp_data", rdata_a, 64'd16);
      start_a = (i == 2);
      tick();
    end
    start_a = 0;
    check("out_busy", 64'(busy_a), 1);
    rready_a = 1; tick(); rready_a = 0;
    check("bp2_valid", 64'(rvalid_a), 1);
    check("bp2_chan", 64'(rchan_a), 1);
    check("bp2_data", rdata_a, 64'd144);
    tick(); tick();
    check("bp3_chan", 64'(rchan_a), 1);
    din_a[0] = 29'd2; dref_a[0] = 29'd0; din_a[1] = 29'd0; dref_a[1] = 29'd0;
    rready_a = 1;
    wait_done(0);

    // Window 4: start accepted in the done cycle
    check("done_cycle_busy", 64'(busy_a), 0);
    qa.push_back('{0, 64'd64}); qa.push_back('{1, 64'd0});
    start_a = 1; tick(); start_a = 0;
    check("restart_busy", 64'(busy_a), 1);
    wait_done(0); tick();

    // Saturation with 8-bit accumulators
    din_b[0] = 29'd10; din_b[1] = 29'd1;
    qb.push_back('{0, 64'd255}); qb.push_back('{1, 64'd16});
    start_b = 1; tick(); start_b = 0;
    wait_done(1); tick();

    // Full-range single sample: (2^29-1)^2 without wrap
    din_c[0] = 29'h1000_0000; dref_c[0] = 29'h0FFF_FFFF;
    qc.push_back('{0, 64'd288230375077969921});
    start_c = 1; tick(); start_c = 0;
    wait_done(2); tick();

    // Reset mid-ACCUM aborts, then a clean window
    din_a[0] = 29'd9; dref_a[0] = 29'd0;
    start_a = 1; tick(); start_a = 0;
    repeat (8) tick();
    #2 rstn = 0;
    #1;
    check("arst_busy", 64'(busy_a), 0);
    check("arst_valid", 64'(rvalid_a), 0);
    check("arst_data", rdata_a, 0);
    check("arst_done", 64'(done_a), 0);
    @(posedge clk); #1 rstn = 1;
    tick();
    din_a[0] = 29'd3; dref_a[0] = 29'd0; din_a[1] = 29'd0; dref_a[1] = 29'd1;
    qa.push_back('{0, 64'd144}); qa.push_back('{1, 64'd16});
    start_a = 1; tick(); start_a = 0;
    wait_done(0); tick(); tick();

    check("qa_left", 64'(qa.size()), 0);
    check("qb_left", 64'(qb.size()), 0);
    check("qc_left", 64'(qc.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
